// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the fetch-stage next-PC sequencer:
//   PC_W        - fetch address width (64)
//   MAX_ILEN    - longest instruction in bytes (10)
//   seq_state_t - sequencer FSM encoding (RUN=0, RET_WAIT=1, HALT=2)
//   seq_next_pc - sequential successor of a PC, wrapping modulo 2^PC_W
// ---------------------------------------------------------------------------
package pc_seq_pkg;

   localparam int PC_W     = 64;
   localparam int MAX_ILEN = 10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } seq_state_t;

   // The 4-bit length is zero-extended, so the sum simply wraps past the top
   // of the address space.
   function automatic logic [PC_W-1:0] seq_next_pc(input logic [PC_W-1:0] pc,
                                                   input logic [3:0]      ilen);
      return pc + {{(PC_W-4){1'b0}}, ilen};
   endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
// Circular return-address stack used to predict return targets.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the stack)
//   clear       - empty the stack (execute-stage redirect)
//   push        - write push_data as the new top; when full, the oldest
//                 entry is overwritten and the count stays at DEPTH
//   pop         - discard the top entry (ignored when empty)
//   push_data   - return address to push
//   top         - most recently pushed entry still on the stack
//   empty, full - occupancy flags
// Parameter DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module ret_addr_stack
   import pc_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top,
   output logic            empty,
   output logic            full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] count;

   // wr_ptr always points at the slot the next push will write, so the top
   // lives one slot below it. Because DEPTH is a power of two the pointer
   // wraps on its own, and a push onto a full stack lands on the oldest entry.
   assign top_idx = wr_ptr - PTR_W'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));

   // Pointer and occupancy bookkeeping; clear wins over any push or pop
   // issued in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (!full) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         wr_ptr <= top_idx;
         count  <= count - CNT_W'(1);
      end
   end

   // Entry storage carries no reset; entries are only read while counted.
   always_ff @(posedge clk) begin
      if (push && !reset && !clear) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage next-PC controller. Owns the fetch PC and each cycle picks
// between sequential advance, predicted jump/call/return, stall hold,
// execute-stage redirect, waiting for a return target, and halt.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   stall             - hold PC, state and return stack this cycle
//   ins_valid         - decode fields describe the instruction at pc_out
//   ilen              - instruction length in bytes (1..10)
//   is_jump/is_call/is_ret/is_halt - decoded control-flow class
//   dest              - jump/call target
//   redirect_valid    - execute-stage correction, beats everything but reset
//   redirect_pc       - corrected PC
//   pc_out            - current fetch PC
//   pc_valid          - pc_out is a real fetch address (RUN only)
//   halted            - sequencer is in HALT
//   state             - FSM state (RUN=0, RET_WAIT=1, HALT=2)
// Configuration macro: PC_SEQ_RAS_EN instantiates a RAS_DEPTH-entry return
// stack that predicts returns; without it every return waits in RET_WAIT
// for a redirect.
// ---------------------------------------------------------------------------
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int          RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            ins_valid,
   input  logic [3:0]      ilen,
   input  logic            is_jump,
   input  logic            is_call,
   input  logic            is_ret,
   input  logic            is_halt,
   input  logic [PC_W-1:0] dest,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic            halted,
   output logic [1:0]      state
);

   seq_state_t      cur_state;
   logic            advance;
   logic            ras_empty;
   logic [PC_W-1:0] ras_top;

   // An instruction is acted on only in RUN, with valid decode, and when
   // nothing of higher priority (reset, redirect, stall) claims the cycle.
   assign advance = !reset && !redirect_valid && !stall &&
                    (cur_state == ST_RUN) && ins_valid;

   assign state = cur_state;

`ifdef PC_SEQ_RAS_EN
   logic ras_push;
   logic ras_pop;

   // Halt and ret outrank call, so a call only pushes when it is the
   // winning flag. A pop is only issued when there is something to pop.
   assign ras_push = advance && !is_halt && !is_ret && is_call;
   assign ras_pop  = advance && !is_halt && is_ret && !ras_empty;

   ret_addr_stack #(
      .DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .reset    (reset),
      .clear    (redirect_valid),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_data(seq_next_pc(pc_out, ilen)),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     ()
   );
`else
   assign ras_empty = 1'b1;
   assign ras_top   = '0;
`endif

   // Sequencer FSM. pc_valid and halted are registered alongside the state
   // so they always describe the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out    <= RESET_PC;
         cur_state <= ST_RUN;
         pc_valid  <= 1'b1;
         halted    <= 1'b0;
      end else if (redirect_valid) begin
         pc_out    <= redirect_pc;
         cur_state <= ST_RUN;
         pc_valid  <= 1'b1;
         halted    <= 1'b0;
      end else if (advance) begin
         if (is_halt) begin
            cur_state <= ST_HALT;
            pc_valid  <= 1'b0;
            halted    <= 1'b1;
         end else if (is_ret) begin
            if (!ras_empty) begin
               pc_out <= ras_top;
            end else begin
               cur_state <= ST_RET_WAIT;
               pc_valid  <= 1'b0;
            end
         end else if (is_call || is_jump) begin
            pc_out <= dest;
         end else begin
            pc_out <= seq_next_pc(pc_out, ilen);
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed scenario tables followed by
// randomized traffic compared against a queue-based reference model.
// Honors PC_SEQ_RAS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif
   localparam int RAS_DEPTH = 4;

   localparam logic [3:0] F_N = 4'b0000;
   localparam logic [3:0] F_J = 4'b0001;
   localparam logic [3:0] F_C = 4'b0010;
   localparam logic [3:0] F_R = 4'b0100;
   localparam logic [3:0] F_H = 4'b1000;

   // One cycle of stimulus plus the state the sequencer must show afterwards.
   // Flags are {halt, ret, call, jump}.
   typedef struct packed {
      logic        rst;
      logic        stl;
      logic        iv;
      logic [3:0]  il;
      logic [3:0]  fl;
      logic [63:0] d;
      logic        rv;
      logic [63:0] rpc;
      logic [63:0] epc;
      logic [1:0]  est;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        ins_valid = 1'b0;
   logic [3:0]  ilen = 4'd1;
   logic        is_jump = 1'b0;
   logic        is_call = 1'b0;
   logic        is_ret = 1'b0;
   logic        is_halt = 1'b0;
   logic [63:0] dest = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic [63:0] pc_out;
   logic        pc_valid;
   logic        halted;
   logic [1:0]  state;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: the PC, the state number and the return stack as a
   // queue whose back is the most recent return address.
   logic [63:0] m_pc = '0;
   int          m_st = 0;
   logic [63:0] m_ras [$];

   pc_sequencer #(
      .RESET_PC (64'h0),
      .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .ins_valid     (ins_valid),
      .ilen          (ilen),
      .is_jump       (is_jump),
      .is_call       (is_call),
      .is_ret        (is_ret),
      .is_halt       (is_halt),
      .dest          (dest),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .pc_out        (pc_out),
      .pc_valid      (pc_valid),
      .halted        (halted),
      .state         (state)
   );

   always #5 clk = ~clk;

   // Apply the architectural rules to the model for one clock edge.
   function automatic void model_step(input vec_t v);
      if (v.rst) begin
         m_pc = 64'h0;
         m_st = 0;
         m_ras.delete();
      end else if (v.rv) begin
         m_pc = v.rpc;
         m_st = 0;
         m_ras.delete();
      end else if (!v.stl && m_st == 0 && v.iv) begin
         if (v.fl[3]) begin
            m_st = 2;
         end else if (v.fl[2]) begin
            if (RAS_EN && m_ras.size() > 0) m_pc = m_ras.pop_back();
            else m_st = 1;
         end else if (v.fl[1]) begin
            if (RAS_EN) begin
               m_ras.push_back(m_pc + 64'(v.il));
               if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end
            m_pc = v.d;
         end else if (v.fl[0]) begin
            m_pc = v.d;
         end else begin
            m_pc = m_pc + 64'(v.il);
         end
      end
   endfunction

   // Drive one cycle of inputs away from the edge, clock it, advance the
   // model, then leave time for the outputs to settle before checks.
   task automatic drive(input vec_t v);
      @(negedge clk);
      reset          = v.rst;
      stall          = v.stl;
      ins_valid      = v.iv;
      ilen           = v.il;
      is_jump        = v.fl[0];
      is_call        = v.fl[1];
      is_ret         = v.fl[2];
      is_halt        = v.fl[3];
      dest           = v.d;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   task automatic test_reset();
      vec_t tbl [2];
      tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd1, F_N, 64'h0, 1'b0, 64'hDEADBEEF_DEADBEEF, 64'h0, 2'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 4'd5, F_J, 64'h777, 1'b0, 64'hDEADBEEF_DEADBEEF, 64'h0, 2'd0};
      for (int i = 0; i < 2; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL reset[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   task automatic test_sequential();
      vec_t tbl [5];
      tbl[0] = '{1'b0, 1'b0, 1'b1, 4'd9,  F_N, 64'h0, 1'b0, 64'h0, 64'h9,  2'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 4'd5,  F_N, 64'h0, 1'b0, 64'h0, 64'h9,  2'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd1,  F_N, 64'h0, 1'b0, 64'h0, 64'hA,  2'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd10, F_N, 64'h0, 1'b0, 64'h0, 64'h14, 2'd0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd7,  F_J, 64'h9, 1'b0, 64'h0, 64'h14, 2'd0};
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL sequential[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   task automatic test_call_ret();
      vec_t tbl [5];
      tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,   1'b1, 64'h100, 64'h100, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 4'd9, F_C, 64'h400, 1'b0, 64'h0,   64'h400, 2'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd3, F_R, 64'h0,   1'b0, 64'h0,
                 RAS_EN ? 64'h109 : 64'h400, RAS_EN ? 2'd0 : 2'd1};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd4, F_N, 64'h0,   1'b0, 64'h0,
                 RAS_EN ? 64'h10D : 64'h400, RAS_EN ? 2'd0 : 2'd1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,   1'b1, 64'h109, 64'h109, 2'd0};
      for (int i = 0; i < 5; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL call_ret[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   task automatic test_ret_empty();
      vec_t tbl [4];
      tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,   1'b1, 64'h300, 64'h300, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 4'd2, F_R, 64'h0,   1'b0, 64'h0,   64'h300, 2'd1};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd2, F_J, 64'h888, 1'b0, 64'h0,   64'h300, 2'd1};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd2, F_N, 64'h0,   1'b1, 64'h200, 64'h200, 2'd0};
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL ret_empty[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   task automatic test_halt();
      vec_t tbl [11];
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,   1'b1, 64'h50, 64'h50, 2'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd2, F_H, 64'h0,   1'b0, 64'h0,  64'h50, 2'd2};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd4, F_N, 64'h0,   1'b0, 64'h0,  64'h50, 2'd2};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd4, F_J, 64'h900, 1'b0, 64'h0,  64'h50, 2'd2};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd4, F_R, 64'h0,   1'b0, 64'h0,  64'h50, 2'd2};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'd4, F_C, 64'h900, 1'b0, 64'h0,  64'h50, 2'd2};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd4, F_N, 64'h0,   1'b0, 64'h0,  64'h50, 2'd2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,   1'b1, 64'h60, 64'h60, 2'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd3, F_H, 64'h0,   1'b0, 64'h0,  64'h60, 2'd2};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'd3, F_N, 64'h0,   1'b0, 64'h0,  64'h0,  2'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd3, F_H | F_J, 64'h5, 1'b0, 64'h0, 64'h0, 2'd2};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL halt[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   task automatic test_wrap();
      vec_t tbl [4];
      tbl[0] = '{1'b0, 1'b0, 1'b0, 4'd1,  F_N, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 4'd4,  F_N, 64'h0, 1'b0, 64'h0, 64'h0, 2'd0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd2,  F_J, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF6, 2'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd10, F_N, 64'h0, 1'b0, 64'h0, 64'h0, 2'd0};
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL wrap[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   // Five nested calls overflow a four-entry stack; the returns must come
   // back in LIFO order with the oldest address lost.
   task automatic test_ras_overflow();
      vec_t tbl [11];
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd1, F_N, 64'h0,    1'b1, 64'h1000, 64'h1000, 2'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd1, F_C, 64'h2000, 1'b0, 64'h0, 64'h2000, 2'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd2, F_C, 64'h3000, 1'b0, 64'h0, 64'h3000, 2'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd3, F_C, 64'h4000, 1'b0, 64'h0, 64'h4000, 2'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd4, F_C, 64'h5000, 1'b0, 64'h0, 64'h5000, 2'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd5, F_C | F_J, 64'h6000, 1'b0, 64'h0, 64'h6000, 2'd0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd1, F_R | F_C, 64'h7000, 1'b0, 64'h0,
                  RAS_EN ? 64'h5005 : 64'h6000, RAS_EN ? 2'd0 : 2'd1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, F_R, 64'h0, 1'b0, 64'h0,
                  RAS_EN ? 64'h4004 : 64'h6000, RAS_EN ? 2'd0 : 2'd1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, F_R, 64'h0, 1'b0, 64'h0,
                  RAS_EN ? 64'h3003 : 64'h6000, RAS_EN ? 2'd0 : 2'd1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd1, F_R, 64'h0, 1'b0, 64'h0,
                  RAS_EN ? 64'h2002 : 64'h6000, RAS_EN ? 2'd0 : 2'd1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd1, F_R, 64'h0, 1'b0, 64'h0,
                  RAS_EN ? 64'h2002 : 64'h6000, 2'd1};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i]);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {tbl[i].epc, tbl[i].est, tbl[i].est == 2'd0, tbl[i].est == 2'd2}) begin
            n_miss++;
            $display("[TB] FAIL ras_overflow[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, tbl[i].epc, tbl[i].est);
         end
      end
   endtask

   // Random traffic: decode fields follow the model PC, flags are mostly
   // single but occasionally stacked, with sprinkled stalls, redirects and
   // resets to exercise recovery from RET_WAIT and HALT.
   task automatic test_random();
      vec_t v;
      int   r;
      for (int i = 0; i < 600; i++) begin
         v = '0;
         v.rst = ($urandom_range(0, 99) < 2);
         v.stl = ($urandom_range(0, 99) < 15);
         v.iv  = ($urandom_range(0, 99) < 85);
         v.il  = 4'($urandom_range(1, 10));
         v.d   = {32'($urandom), 32'($urandom)};
         v.rv  = ($urandom_range(0, 99) < 7);
         v.rpc = {32'($urandom), 32'($urandom)};
         r = $urandom_range(0, 99);
         if (r < 40)      v.fl = F_N;
         else if (r < 55) v.fl = F_J;
         else if (r < 72) v.fl = F_C;
         else if (r < 90) v.fl = F_R;
         else if (r < 93) v.fl = F_H;
         else             v.fl = 4'($urandom_range(0, 15));
         drive(v);
         n_vec++;
         if ({pc_out, state, pc_valid, halted} !== {m_pc, 2'(m_st), m_st == 0, m_st == 2}) begin
            n_miss++;
            $display("[TB] FAIL random[%0d]: got pc=%h state=%0d valid=%b halted=%b, want pc=%h state=%0d", i, pc_out, state, pc_valid, halted, m_pc, m_st);
         end
      end
   endtask

   initial begin
      $display("[TB] pc_sequencer bench, return stack %s", RAS_EN ? "enabled" : "disabled");
      test_reset();
      test_sequential();
      test_call_ret();
      test_ret_empty();
      test_halt();
      test_wrap();
      test_ras_overflow();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
